// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dma_pkg
//  Brief    : Shared constants, command/mode bit-field types and a byte
//             insert helper for the DMA CPU register block.
//  Revision : 1.0 - initial release
// ============================================================================
package dma_pkg;

    // CPU-visible register addresses in the upper half of the map
    localparam logic [3:0] ADDR_CMD_STAT  = 4'h8;  // wr command / rd status
    localparam logic [3:0] ADDR_REQ       = 4'h9;  // single request bit
    localparam logic [3:0] ADDR_MASK_BIT  = 4'hA;  // single mask bit
    localparam logic [3:0] ADDR_MODE      = 4'hB;  // mode register
    localparam logic [3:0] ADDR_CLR_FF    = 4'hC;  // clear byte pointer
    localparam logic [3:0] ADDR_MCLR_TEMP = 4'hD;  // wr master clear / rd temp
    localparam logic [3:0] ADDR_CLR_MASK  = 4'hE;  // clear all mask bits
    localparam logic [3:0] ADDR_WR_MASK   = 4'hF;  // load all mask bits

    // All four channels masked out of reset and master clear
    localparam logic [7:0] MASK_RST = 8'h0F;

    // Command register bit fields
    typedef struct packed {
        logic dackSense;
        logic dreqSense;
        logic extWrite;
        logic rotPrio;
        logic compTiming;
        logic ctrlDisable;
        logic ch0Hold;
        logic memToMem;
    } cmd_t;

    // Mode register fields (DB[7:2] of a mode write)
    typedef struct packed {
        logic [1:0] mode;
        logic       addrDec;
        logic       autoInit;
        logic [1:0] xferType;
    } mode_t;

    // Replace the low (hi=0) or high (hi=1) byte of a 16-bit register
    function automatic logic [15:0] set_byte(input logic [15:0] v,
                                             input logic        hi,
                                             input logic [7:0]  b);
        return hi ? {b, v[7:0]} : {v[15:8], b};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dma_reg_if.sv
`default_nettype none
// ============================================================================
//  Module   : dma_reg_if
//  Brief    : Register-file view shared between the CPU register block (REG,
//             producer) and the transfer engine (ENG, consumer).
//  Revision : 1.0 - initial release
// ============================================================================
interface dma_reg_if;
    import dma_pkg::*;

    logic [3:0][15:0] baseAddr;
    logic [3:0][15:0] baseWord;
    logic [3:0][15:0] curAddr;
    logic [3:0][15:0] curWord;
    cmd_t             commandReg;
    logic [7:0]       statusReg;
    logic [7:0]       requestReg;
    logic [7:0]       maskReg;
    mode_t [3:0]      modeReg;
    logic [7:0]       tempReg;
    logic             bytePtr;

    modport REG (
        output baseAddr, baseWord, curAddr, curWord, commandReg, statusReg,
               requestReg, maskReg, modeReg, tempReg, bytePtr
    );

    modport ENG (
        input  baseAddr, baseWord, curAddr, curWord, commandReg, statusReg,
               requestReg, maskReg, modeReg, tempReg, bytePtr
    );

endinterface
`default_nettype wire

// File: rtl/dma_cpu_reg.sv
`default_nettype none
// ============================================================================
//  Module   : dma_cpu_reg
//  Brief    : 8237-style CPU register file for a 4-channel DMA controller.
//             CPU accesses commit on the trailing edge of IOR_N/IOW_N.
//             Optional build macro DMA_TEMP_REG_EN adds a loadable temp
//             register (ports tempLd/tempData); otherwise tempReg reads 0.
//  Revision : 1.0 - initial release
// ============================================================================
module dma_cpu_reg
    import dma_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                CS_N,
    input  logic                IOR_N,
    input  logic                IOW_N,
    input  logic [3:0]          A,
    input  logic [7:0]          DB_IN,
    output logic [7:0]          DB_OUT,
    output logic                DB_OE,
    input  logic [NUM_CH-1:0]   DREQ,
    input  logic [NUM_CH-1:0]   tcSet,
    input  logic [NUM_CH-1:0]   autoInitLd,
    input  logic                updEn,
    input  logic [1:0]          updCh,
    input  logic [15:0]         updAddr,
    input  logic [15:0]         updWord,
`ifdef DMA_TEMP_REG_EN
    input  logic                tempLd,
    input  logic [7:0]          tempData,
`endif
    dma_reg_if.REG              rif
);

    localparam int CH_W = $clog2(NUM_CH);

    // Strobe samplers (idle high) and access latches
    logic            csN_q, iorN_q, iowN_q;
    logic [3:0]      aLat_q;
    logic [7:0]      dbLat_q;
    logic            rdCommit, wrCommit;
    logic [CH_W-1:0] wrCh;

    // Register file state
    logic [NUM_CH-1:0][15:0] baseAddr_q, baseAddr_d;
    logic [NUM_CH-1:0][15:0] baseWord_q, baseWord_d;
    logic [NUM_CH-1:0][15:0] curAddr_q,  curAddr_d;
    logic [NUM_CH-1:0][15:0] curWord_q,  curWord_d;
    logic [NUM_CH-1:0][5:0]  modeReg_q,  modeReg_d;
    logic [7:0]              commandReg_q, commandReg_d;
    logic [7:0]              statusReg_q,  statusReg_d;
    logic [7:0]              requestReg_q, requestReg_d;
    logic [7:0]              maskReg_q,    maskReg_d;
    logic [7:0]              tempReg_q,    tempReg_d;
    logic                    bytePtr_q,    bytePtr_d;

    // Sample the bus strobes each cycle and hold address/data of the live access
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            csN_q   <= 1'b1;
            iorN_q  <= 1'b1;
            iowN_q  <= 1'b1;
            aLat_q  <= '0;
            dbLat_q <= '0;
        end else begin
            csN_q  <= CS_N;
            iorN_q <= IOR_N;
            iowN_q <= IOW_N;
            if (!CS_N && (!IOR_N || !IOW_N)) begin
                aLat_q <= A;
            end
            if (!IOW_N) begin
                dbLat_q <= DB_IN;
            end
        end
    end

    // A strobe seen high right after a selected low sample is the trailing edge
    assign rdCommit = !csN_q && !iorN_q && IOR_N;
    assign wrCommit = !csN_q && !iowN_q && IOW_N;
    assign wrCh     = aLat_q[CH_W:1];

    // Next-state for all registers: engine updates first, CPU writes override
    always_comb begin
        baseAddr_d   = baseAddr_q;
        baseWord_d   = baseWord_q;
        curAddr_d    = curAddr_q;
        curWord_d    = curWord_q;
        modeReg_d    = modeReg_q;
        commandReg_d = commandReg_q;
        requestReg_d = requestReg_q;
        maskReg_d    = maskReg_q;
        bytePtr_d    = bytePtr_q;
        tempReg_d    = tempReg_q;

        // Upper nibble mirrors DREQ; TC flags clear on a status read but a
        // same-cycle terminal count still sets them
        statusReg_d = {DREQ, statusReg_q[3:0]};
        if (rdCommit && (aLat_q == ADDR_CMD_STAT)) begin
            statusReg_d[3:0] = 4'h0;
        end
        statusReg_d[3:0] = statusReg_d[3:0] | tcSet;

`ifdef DMA_TEMP_REG_EN
        if (tempLd) begin
            tempReg_d = tempData;
        end
`else
        tempReg_d = 8'h00;
`endif

        // Transfer-engine write-back, then auto-init reload of base values
        if (updEn) begin
            curAddr_d[updCh] = updAddr;
            curWord_d[updCh] = updWord;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (autoInitLd[i]) begin
                curAddr_d[i] = baseAddr_q[i];
                curWord_d[i] = baseWord_q[i];
            end
        end

        // Flip-flop pointer advances on every committed channel register access
        if ((rdCommit || wrCommit) && !aLat_q[3]) begin
            bytePtr_d = ~bytePtr_q;
        end

        if (wrCommit) begin
            if (!aLat_q[3]) begin
                // CPU byte replaces the whole pending engine value for that register
                if (aLat_q[0]) begin
                    baseWord_d[wrCh] = set_byte(baseWord_q[wrCh], bytePtr_q, dbLat_q);
                    curWord_d[wrCh]  = set_byte(curWord_q[wrCh],  bytePtr_q, dbLat_q);
                end else begin
                    baseAddr_d[wrCh] = set_byte(baseAddr_q[wrCh], bytePtr_q, dbLat_q);
                    curAddr_d[wrCh]  = set_byte(curAddr_q[wrCh],  bytePtr_q, dbLat_q);
                end
            end else begin
                case (aLat_q)
                    ADDR_CMD_STAT:  commandReg_d = dbLat_q;
                    ADDR_REQ:       requestReg_d[dbLat_q[1:0]] = dbLat_q[2];
                    ADDR_MASK_BIT:  maskReg_d[dbLat_q[1:0]] = dbLat_q[2];
                    ADDR_MODE:      modeReg_d[dbLat_q[1:0]] = dbLat_q[7:2];
                    ADDR_CLR_FF:    bytePtr_d = 1'b0;
                    ADDR_MCLR_TEMP: begin
                        commandReg_d = 8'h00;
                        statusReg_d  = 8'h00;
                        requestReg_d = 8'h00;
                        tempReg_d    = 8'h00;
                        bytePtr_d    = 1'b0;
                        maskReg_d    = MASK_RST;
                    end
                    ADDR_CLR_MASK:  maskReg_d = 8'h00;
                    ADDR_WR_MASK:   maskReg_d = {4'h0, dbLat_q[3:0]};
                    default:        ;
                endcase
            end
        end

        // Only four channels exist, so the upper request/mask bits stay zero
        requestReg_d[7:4] = 4'h0;
        maskReg_d[7:4]    = 4'h0;
    end

    // Register file state with asynchronous clear
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            baseAddr_q   <= '0;
            baseWord_q   <= '0;
            curAddr_q    <= '0;
            curWord_q    <= '0;
            modeReg_q    <= '0;
            commandReg_q <= '0;
            statusReg_q  <= '0;
            requestReg_q <= '0;
            maskReg_q    <= MASK_RST;
            tempReg_q    <= '0;
            bytePtr_q    <= 1'b0;
        end else begin
            baseAddr_q   <= baseAddr_d;
            baseWord_q   <= baseWord_d;
            curAddr_q    <= curAddr_d;
            curWord_q    <= curWord_d;
            modeReg_q    <= modeReg_d;
            commandReg_q <= commandReg_d;
            statusReg_q  <= statusReg_d;
            requestReg_q <= requestReg_d;
            maskReg_q    <= maskReg_d;
            tempReg_q    <= tempReg_d;
            bytePtr_q    <= bytePtr_d;
        end
    end

    // Combinational read mux, active only while a read strobe is selected
    always_comb begin
        DB_OUT = 8'h00;
        DB_OE  = 1'b0;
        if (RESET && !CS_N && !IOR_N) begin
            DB_OE = 1'b1;
            if (!A[3]) begin
                if (A[0]) begin
                    DB_OUT = bytePtr_q ? curWord_q[A[CH_W:1]][15:8] : curWord_q[A[CH_W:1]][7:0];
                end else begin
                    DB_OUT = bytePtr_q ? curAddr_q[A[CH_W:1]][15:8] : curAddr_q[A[CH_W:1]][7:0];
                end
            end else if (A == ADDR_CMD_STAT) begin
                DB_OUT = statusReg_q;
            end else if (A == ADDR_MCLR_TEMP) begin
                DB_OUT = tempReg_q;
            end
        end
    end

    assign rif.baseAddr   = baseAddr_q;
    assign rif.baseWord   = baseWord_q;
    assign rif.curAddr    = curAddr_q;
    assign rif.curWord    = curWord_q;
    assign rif.commandReg = commandReg_q;
    assign rif.statusReg  = statusReg_q;
    assign rif.requestReg = requestReg_q;
    assign rif.maskReg    = maskReg_q;
    assign rif.modeReg    = modeReg_q;
    assign rif.tempReg    = tempReg_q;
    assign rif.bytePtr    = bytePtr_q;

endmodule
`default_nettype wire

// File: tb/tb_dma_cpu_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dma_cpu_reg
//  Brief    : Directed, scoreboard-checked bench for dma_cpu_reg.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dma_cpu_reg;

    logic        CLK;
    logic        RESET;
    logic        CS_N, IOR_N, IOW_N;
    logic [3:0]  A;
    logic [7:0]  DB_IN;
    logic [7:0]  DB_OUT;
    logic        DB_OE;
    logic [3:0]  DREQ, tcSet, autoInitLd;
    logic        updEn;
    logic [1:0]  updCh;
    logic [15:0] updAddr, updWord;
`ifdef DMA_TEMP_REG_EN
    logic        tempLd;
    logic [7:0]  tempData;
`endif

    dma_reg_if rif_u ();

    dma_cpu_reg #(.NUM_CH(4)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .CS_N       (CS_N),
        .IOR_N      (IOR_N),
        .IOW_N      (IOW_N),
        .A          (A),
        .DB_IN      (DB_IN),
        .DB_OUT     (DB_OUT),
        .DB_OE      (DB_OE),
        .DREQ       (DREQ),
        .tcSet      (tcSet),
        .autoInitLd (autoInitLd),
        .updEn      (updEn),
        .updCh      (updCh),
        .updAddr    (updAddr),
        .updWord    (updWord),
`ifdef DMA_TEMP_REG_EN
        .tempLd     (tempLd),
        .tempData   (tempData),
`endif
        .rif        (rif_u)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Scoreboard: expectations queued with the stimulus, popped at sampling
    string       tagq[$];
    logic [15:0] expq[$];
    int          n_cmp = 0;
    int          n_mis = 0;

    // Side effects applied on the commit cycle of the next CPU access
    logic [3:0]  sideTc  = 4'h0;
    logic        sideUpd = 1'b0;

    task automatic sb_push(input string tag, input logic [15:0] v);
        tagq.push_back(tag);
        expq.push_back(v);
    endtask

    task automatic sb_check(input logic [15:0] obs);
        string       t;
        logic [15:0] e;
        n_cmp++;
        if (expq.size() == 0) begin
            n_mis++;
            $display("FAIL sb_empty observed=%h required=queued_entry", obs);
            return;
        end
        t = tagq.pop_front();
        e = expq.pop_front();
        assert (obs === e) else begin
            n_mis++;
            $error("FAIL %s observed=%h required=%h", t, obs, e);
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] v);
        sb_push(tag, v);
        sb_check(obs);
    endtask

    task automatic apply_side();
        tcSet = sideTc;
        updEn = sideUpd;
    endtask

    task automatic clear_side();
        tcSet   = 4'h0;
        updEn   = 1'b0;
        sideTc  = 4'h0;
        sideUpd = 1'b0;
    endtask

    task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
        @(posedge CLK); #1;
        A = a; DB_IN = d; CS_N = 1'b0; IOW_N = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        IOW_N = 1'b1; CS_N = 1'b1;
        apply_side();
        @(posedge CLK); #1;
        clear_side();
    endtask

    task automatic cpu_rd(input logic [3:0] a, input logic [7:0] v, input string tag);
        sb_push(tag, {8'h00, v});
        @(posedge CLK); #1;
        A = a; CS_N = 1'b0; IOR_N = 1'b0;
        @(negedge CLK);
        sb_check({8'h00, DB_OUT});
        chk({tag, "_oe"}, {15'h0, DB_OE}, 16'h0001);
        @(posedge CLK); #1;
        IOR_N = 1'b1; CS_N = 1'b1;
        apply_side();
        @(posedge CLK); #1;
        clear_side();
    endtask

    task automatic pulse_tc(input logic [3:0] v);
        @(posedge CLK); #1; tcSet = v;
        @(posedge CLK); #1; tcSet = 4'h0;
    endtask

    // Hard stop if the sequence ever stalls
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET = 1'b0; CS_N = 1'b1; IOR_N = 1'b1; IOW_N = 1'b1;
        A = 4'h0; DB_IN = 8'h00; DREQ = 4'h0; tcSet = 4'h0; autoInitLd = 4'h0;
        updEn = 1'b0; updCh = 2'd0; updAddr = 16'h0; updWord = 16'h0;
`ifdef DMA_TEMP_REG_EN
        tempLd = 1'b0; tempData = 8'h00;
`endif
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b1;
        @(negedge CLK);

        // Reset state
        chk("rst_mask",   {8'h00, rif_u.maskReg},    16'h000F);
        chk("rst_cmd",    {8'h00, rif_u.commandReg}, 16'h0000);
        chk("rst_status", {8'h00, rif_u.statusReg},  16'h0000);
        chk("rst_ptr",    {15'h0, rif_u.bytePtr},    16'h0000);
        chk("rst_db_oe",  {15'h0, DB_OE},            16'h0000);
        chk("rst_db_out", {8'h00, DB_OUT},           16'h0000);

        // Write strobe cut short by reset must never commit
        @(posedge CLK); #1;
        A = 4'h8; DB_IN = 8'hAA; CS_N = 1'b0; IOW_N = 1'b0;
        @(posedge CLK); @(posedge CLK); #1;
        RESET = 1'b0;
        #2 IOW_N = 1'b1; CS_N = 1'b1;
        @(posedge CLK); #1 RESET = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("abort_cmd", {8'h00, rif_u.commandReg}, 16'h0000);

        // Byte order: low then high
        cpu_wr(4'h0, 8'h34);
        cpu_wr(4'h0, 8'h12);
        @(negedge CLK);
        chk("ch0_base_addr", rif_u.baseAddr[0], 16'h1234);
        chk("ch0_cur_addr",  rif_u.curAddr[0],  16'h1234);
        cpu_rd(4'h0, 8'h34, "rd_ch0_lo");
        cpu_rd(4'h0, 8'h12, "rd_ch0_hi");

        // Byte pointer clear
        cpu_wr(4'h2, 8'h55);
        cpu_wr(4'hC, 8'h00);
        cpu_wr(4'h2, 8'h66);
        @(negedge CLK);
        chk("ch1_base_addr", rif_u.baseAddr[1], 16'h0066);
        chk("ptr_high",      {15'h0, rif_u.bytePtr}, 16'h0001);
        cpu_wr(4'hC, 8'h00);

        // Word count register
        cpu_wr(4'h3, 8'hCD);
        cpu_wr(4'h3, 8'hAB);
        @(negedge CLK);
        chk("ch1_base_word", rif_u.baseWord[1], 16'hABCD);
        cpu_rd(4'h3, 8'hCD, "rd_ch1_wc_lo");
        cpu_rd(4'h3, 8'hAB, "rd_ch1_wc_hi");

        // Terminal count versus status read
        pulse_tc(4'b0100);
        cpu_rd(4'h8, 8'h04, "stat_tc2");
        cpu_rd(4'h8, 8'h00, "stat_cleared");
        sideTc = 4'b0100;
        cpu_rd(4'h8, 8'h00, "stat_tc_on_commit");
        cpu_rd(4'h8, 8'h04, "stat_set_wins");
        cpu_rd(4'h8, 8'h00, "stat_cleared2");

        // Status upper nibble tracks DREQ
        @(posedge CLK); #1 DREQ = 4'b1010;
        repeat (2) @(posedge CLK);
        cpu_rd(4'h8, 8'hA0, "stat_dreq");
        #1 DREQ = 4'h0;
        repeat (2) @(posedge CLK);

        // Mask and request
        cpu_wr(4'hA, 8'h02);
        @(negedge CLK);
        chk("mask_clr_bit2", {8'h00, rif_u.maskReg}, 16'h000B);
        cpu_wr(4'hE, 8'h00);
        @(negedge CLK);
        chk("mask_clr_all", {8'h00, rif_u.maskReg}, 16'h0000);
        cpu_wr(4'h9, 8'h07);
        @(negedge CLK);
        chk("req_set_bit3", {8'h00, rif_u.requestReg}, 16'h0008);
        cpu_wr(4'hF, 8'hF5);
        @(negedge CLK);
        chk("mask_load", {8'h00, rif_u.maskReg}, 16'h0005);
        cpu_rd(4'h9, 8'h00, "rd_write_only");

        // Mode and command
        cpu_wr(4'hB, 8'h96);
        cpu_wr(4'h8, 8'h5A);
        @(negedge CLK);
        chk("mode_ch2", {10'h0, rif_u.modeReg[2]}, 16'h0025);
        chk("cmd_write", {8'h00, rif_u.commandReg}, 16'h005A);

        // Master clear
        pulse_tc(4'b0001);
        cpu_wr(4'hD, 8'h00);
        @(negedge CLK);
        chk("mc_cmd",    {8'h00, rif_u.commandReg}, 16'h0000);
        chk("mc_status", {8'h00, rif_u.statusReg},  16'h0000);
        chk("mc_req",    {8'h00, rif_u.requestReg}, 16'h0000);
        chk("mc_mask",   {8'h00, rif_u.maskReg},    16'h000F);
        chk("mc_mode_kept", {10'h0, rif_u.modeReg[2]}, 16'h0025);
        chk("mc_addr_kept", rif_u.baseAddr[0], 16'h1234);
        cpu_rd(4'hD, 8'h00, "rd_temp");

        // CPU write collides with engine update on channel 3
        updCh = 2'd3; updAddr = 16'hBEEF; updWord = 16'hCAFE;
        sideUpd = 1'b1;
        cpu_wr(4'h6, 8'h77);
        @(negedge CLK);
        chk("coll_cur_addr",  rif_u.curAddr[3],  16'h0077);
        chk("coll_base_addr", rif_u.baseAddr[3], 16'h0077);
        chk("coll_cur_word",  rif_u.curWord[3],  16'hCAFE);

        // Plain engine update leaves base untouched
        @(posedge CLK); #1;
        updEn = 1'b1; updCh = 2'd2; updAddr = 16'h1111; updWord = 16'h2222;
        @(posedge CLK); #1 updEn = 1'b0;
        @(negedge CLK);
        chk("upd_cur_addr",  rif_u.curAddr[2],  16'h1111);
        chk("upd_cur_word",  rif_u.curWord[2],  16'h2222);
        chk("upd_base_addr", rif_u.baseAddr[2], 16'h0000);

        // Auto-init reload restores base
        @(posedge CLK); #1;
        updEn = 1'b1; updCh = 2'd0; updAddr = 16'hAAAA; updWord = 16'h5555;
        @(posedge CLK); #1 updEn = 1'b0;
        @(negedge CLK);
        chk("pre_ai_addr", rif_u.curAddr[0], 16'hAAAA);
        @(posedge CLK); #1 autoInitLd = 4'b0001;
        @(posedge CLK); #1 autoInitLd = 4'b0000;
        @(negedge CLK);
        chk("ai_cur_addr", rif_u.curAddr[0], 16'h1234);
        chk("ai_cur_word", rif_u.curWord[0], 16'h0000);

        repeat (2) @(posedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dma_cpu_reg.md
DMA_CPU_REG -- requirements
Module: dma_cpu_reg

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of DMA channels; only 4 is supported.
REQ-002 SHALL have ports CLK (input, 1, sole clock) and RESET (input, 1); one clock; RESET is asynchronous and active-low.
REQ-003 SHALL have CS_N (input, 1, chip select, active-low).
REQ-004 SHALL have IOR_N and IOW_N (inputs, 1 each, CPU read/write strobes, active-low).
REQ-005 SHALL have A (input, 4, register address).
REQ-006 SHALL have DB_IN (input, 8, write data) and DB_OUT (output, 8, read data).
REQ-007 SHALL have DB_OE (output, 1, read-data enable).
REQ-008 SHALL have DREQ (input, 4, raw channel requests), tcSet (input, 4, terminal-count pulses) and autoInitLd (input, 4, reload pulses).
REQ-009 SHALL have updEn (input, 1), updCh (input, 2), updAddr (input, 16) and updWord (input, 16) as the transfer-engine current-register write port.
REQ-010 SHALL drive the register-interface REG modport as port rif, writing every field in it.

Function
REQ-011 SHALL sample CS_N, IOR_N and IOW_N every CLK and latch DB_IN every cycle a write strobe is asserted.
REQ-012 SHALL commit an access on its trailing edge, i.e. the first cycle a strobe is seen high after being sampled low with CS_N=0; exactly one commit per strobe.
REQ-013 SHALL drive DB_OUT combinationally while CS_N=0 and IOR_N=0, with DB_OE=1; otherwise DB_OUT=8'h00 and DB_OE=0.
REQ-014 A=0xxx: A[2:1] selects the channel, A0=0 the address register, A0=1 the word-count register.
REQ-015 Writes SHALL load the base and current register bytes together; reads SHALL return the current register byte.
REQ-016 The byte pointer (0=low, 1=high) SHALL select the byte and toggle on every committed access to an address or count register.
REQ-017 0x8: write sets commandReg; read returns statusReg.
REQ-018 0x9: write sets or clears requestReg bit DB[1:0] to DB[2].
REQ-019 0xA: write sets or clears maskReg bit DB[1:0] to DB[2].
REQ-020 0xB: write stores DB[7:2] into modeReg[DB[1:0]].
REQ-021 0xC: write clears the byte pointer.
REQ-022 0xD: write is master clear; read returns tempReg.
REQ-023 0xE: write clears maskReg[3:0].
REQ-024 0xF: write loads maskReg[3:0] from DB[3:0].
REQ-025 Reads of write-only addresses SHALL return 8'h00.
REQ-026 requestReg[7:4] and maskReg[7:4] SHALL be held at 0.
REQ-027 statusReg[7:4] SHALL follow DREQ, registered once.
REQ-028 statusReg[3:0] SHALL set on tcSet and clear on a committed status read; if both occur in the same cycle, set wins.
REQ-029 updEn SHALL write updAddr and updWord to the current registers of channel updCh.
REQ-030 autoInitLd[n] SHALL copy base to current for channel n.
REQ-031 A CPU write to the same current register in the same cycle SHALL win over updEn and autoInitLd.
REQ-032 Address and count arithmetic SHALL be done by the transfer engine; this block only stores values, with no wrap logic.
REQ-033 Master clear SHALL zero commandReg, statusReg, requestReg, tempReg and the byte pointer, and set maskReg to 8'h0F; address, count and mode registers are unchanged.

Reset
REQ-034 RESET low SHALL asynchronously zero all registers and the byte pointer, set maskReg to 8'h0F, set DB_OE=0 and DB_OUT=8'h00, and mark the strobe samplers idle (high).
REQ-035 An access in progress when RESET asserts SHALL be discarded and SHALL not commit after release.

Configuration
REQ-036 With DMA_TEMP_REG_EN defined, the block SHALL add inputs tempLd (1) and tempData (8), and load tempReg from tempData when tempLd=1.
REQ-037 Without DMA_TEMP_REG_EN, tempReg SHALL be tied to 8'h00, tempLd and tempData SHALL be absent, and a read of 0xD returns 8'h00.

Structure
REQ-038 SHALL place the register address constants, the command/mode bit-field typedefs and the mask reset value 8'h0F in a shared package dma_pkg.
REQ-039 SHALL be a single module with no sub-modules.

Verification
REQ-040 Reset and byte order: reset, then write 0x0 with 0x34 then 0x12 -> base and current address of channel 0 = 16'h1234; two reads of 0x0 return 0x34 then 0x12.
REQ-041 Byte pointer clear: write 0x2 with 0x55 once, write 0xC, write 0x2 with 0x66 -> low byte of channel 1 address = 0x66 and the pointer is at high.
REQ-042 Terminal count vs status read: tcSet=4'b0100 pulse, read 0x8 -> bit2=1, then 0 on the next read; tcSet on the commit cycle -> bit stays 1.
REQ-043 Mask and request: reset -> maskReg=0x0F; write 0xA with 0x02 -> 0x0B; write 0xE -> 0x00; write 0x9 with 0x07 -> requestReg=0x08.
REQ-044 Master clear and update collision: write 0xD -> command, status and request zero, mask 0x0F; CPU write to channel 3 current address in the same cycle as updEn to channel 3 -> CPU value kept.
